ahb3lite_dma_master: RTL and testbench

AHB-Lite write-only bus master, the initiator side of the CPU/DMA slave path. It accepts a block-write command and issues SINGLE or INCR word transfers on the AHB-Lite bus. Write data is fetched from a local source memory one cycle ahead, so the data phase always carries stable data. It reports completion and error status back to the command issuer.

---
 rtl/ahb3lite_dma_master.sv | 194 +++++++++++++++++++
 tb/tb_ahb3lite_dma_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_dma_master.sv
// AHB-Lite write-only block master: turns a block-write command into SINGLE or INCR
// word transfers, prefetching write data from a local source memory one cycle ahead.
module ahb3lite_dma_master #(
    parameter int LEN_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_incr,
    output logic             src_rd_en,
    output logic [LEN_W-1:0] src_addr,
    input  logic [31:0]      src_rd_data,
    output logic [31:0]      HADDR,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [1:0]       HTRANS,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] beats_ok
);

    localparam logic [1:0] TR_IDLE      = 2'b00;
    localparam logic [1:0] TR_NONSEQ    = 2'b10;
    localparam logic [1:0] TR_SEQ       = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic       RESP_OKAY    = 1'b0;
    localparam logic       RESP_ERROR   = 1'b1;
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_BURST = 3'd2,
        S_LAST  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             incr_r, incr_nxt_s;
    logic [LEN_W-1:0] remaining_r, remaining_nxt_s;
    logic [31:0]      haddr_nxt_s;
    logic [1:0]       htrans_nxt_s;
    logic [2:0]       hburst_nxt_s;
    logic             hwrite_nxt_s;
    logic [LEN_W-1:0] src_addr_nxt_s;
    logic [LEN_W-1:0] beats_nxt_s;
    logic             done_nxt_s;
    logic             err_nxt_s;
    logic             okay_s;

    // HTRANS of a non-first beat: INCR restarts with NONSEQ when crossing a 1KB boundary
    function automatic logic [1:0] next_trans(input logic incr, input logic [9:0] cur_lo);
        if (incr && (cur_lo != 10'h3FC)) begin
            next_trans = TR_SEQ;
        end else begin
            next_trans = TR_NONSEQ;
        end
    endfunction

    assign cmd_ready = (state_r == S_IDLE);
    assign src_rd_en = ((HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ)) && HREADY;
    assign HSIZE     = 3'b010;
    assign HWDATA    = src_rd_data;
    assign okay_s    = (HRESP == RESP_OKAY);

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s     = state_r;
        incr_nxt_s      = incr_r;
        remaining_nxt_s = remaining_r;
        haddr_nxt_s     = HADDR;
        htrans_nxt_s    = HTRANS;
        hburst_nxt_s    = HBURST;
        hwrite_nxt_s    = HWRITE;
        src_addr_nxt_s  = src_rd_en ? (src_addr + LEN_ONE) : src_addr;
        beats_nxt_s     = beats_ok;
        done_nxt_s      = 1'b0;
        err_nxt_s       = err;

        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    beats_nxt_s    = LEN_ZERO;
                    err_nxt_s      = 1'b0;
                    src_addr_nxt_s = LEN_ZERO;
                    if (cmd_len == LEN_ZERO) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s     = S_ADDR;
                        incr_nxt_s      = cmd_incr;
                        remaining_nxt_s = cmd_len;
                        haddr_nxt_s     = cmd_addr & 32'hFFFF_FFFC;
                        htrans_nxt_s    = TR_NONSEQ;
                        hburst_nxt_s    = cmd_incr ? BURST_INCR : BURST_SINGLE;
                        hwrite_nxt_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ADDR, S_BURST: begin
                if (HREADY) begin
                    if (state_r == S_BURST) begin
                        beats_nxt_s = beats_ok + (okay_s ? LEN_ONE : LEN_ZERO);
                    end else begin
                        beats_nxt_s = beats_ok;
                    end
                    if (remaining_r == LEN_ONE) begin
                        state_nxt_s  = S_LAST;
                        htrans_nxt_s = TR_IDLE;
                        hwrite_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s     = S_BURST;
                        remaining_nxt_s = remaining_r - LEN_ONE;
                        haddr_nxt_s     = HADDR + 32'd4;
                        htrans_nxt_s    = next_trans(incr_r, HADDR[9:0]);
                    end
                end else if ((state_r == S_BURST) && (HRESP == RESP_ERROR)) begin
                    // first error cycle: drop the pending address so it is never accepted
                    state_nxt_s  = S_ERR;
                    htrans_nxt_s = TR_IDLE;
                    hwrite_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LAST: begin
                if (HREADY) begin
                    beats_nxt_s = beats_ok + (okay_s ? LEN_ONE : LEN_ZERO);
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = !okay_s;
                    state_nxt_s = S_IDLE;
                end else if (HRESP == RESP_ERROR) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_LAST;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_ERR;
                end
            end
            default: begin
                state_nxt_s  = S_IDLE;
                htrans_nxt_s = TR_IDLE;
                hwrite_nxt_s = 1'b0;
            end
        endcase
    end

    // State register and registered bus/status outputs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r     <= S_IDLE;
            incr_r      <= 1'b0;
            remaining_r <= LEN_ZERO;
            HADDR       <= 32'h0000_0000;
            HTRANS      <= TR_IDLE;
            HBURST      <= BURST_SINGLE;
            HWRITE      <= 1'b0;
            src_addr    <= LEN_ZERO;
            beats_ok    <= LEN_ZERO;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            incr_r      <= incr_nxt_s;
            remaining_r <= remaining_nxt_s;
            HADDR       <= haddr_nxt_s;
            HTRANS      <= htrans_nxt_s;
            HBURST      <= hburst_nxt_s;
            HWRITE      <= hwrite_nxt_s;
            src_addr    <= src_addr_nxt_s;
            beats_ok    <= beats_nxt_s;
            done        <= done_nxt_s;
            err         <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_ahb3lite_dma_master.sv
// Randomized bench for ahb3lite_dma_master: a slave/source model drives the bus and
// every command is checked against a transfer list derived from the command alone.
module tb_ahb3lite_dma_master;

    localparam int LEN_W = 8;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic             HCLK = 1'b0;
    logic             HRESET = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_addr = 32'h0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_incr = 1'b0;
    logic             src_rd_en;
    logic [LEN_W-1:0] src_addr;
    logic [31:0]      src_rd_data;
    logic [31:0]      HADDR;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [1:0]       HTRANS;
    logic [31:0]      HWDATA;
    logic             HREADY = 1'b1;
    logic             HRESP = 1'b0;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] beats_ok;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:255];
    int unsigned src_reads = 0;

    always #5 HCLK = ~HCLK;

    ahb3lite_dma_master #(.LEN_W(LEN_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_incr(cmd_incr),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rd_data(src_rd_data),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .done(done), .err(err), .beats_ok(beats_ok)
    );

    // source memory: registered read, output holds between reads
    always @(posedge HCLK) begin
        if (src_rd_en) begin
            src_rd_data <= mem[src_addr];
            src_reads   <= src_reads + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One command from the idle negedge to its done pulse (or a mid-burst reset).
    task automatic run_cmd(input logic [31:0] addr, input int len, input bit incr,
                           input int ready_pct, input int stall_beat, input int stall_n,
                           input int err_beat, input int reset_at);
        logic [31:0] exp_addr [0:255];
        logic [1:0]  exp_trans [0:255];
        logic [31:0] base, a, prev_addr;
        logic [1:0]  trans, prev_trans;
        logic        rdy, rsp, data_pend, prev_wait, finished;
        int cyc, acc, stalls, data_beat, err_stage, stall_left;
        int exp_ok, exp_acc, exp_cyc;
        int unsigned reads0;
        bit has_err;

        base = addr & 32'hFFFF_FFFC;
        for (int i = 0; i < len; i++) begin
            a = base + 32'(4 * i);
            exp_addr[i]  = a;
            exp_trans[i] = (i == 0 || !incr || a[9:0] == 10'h000) ? T_NONSEQ : T_SEQ;
        end
        has_err = (err_beat >= 0) && (err_beat < len);
        exp_ok  = has_err ? err_beat : len;
        exp_acc = has_err ? err_beat + 1 : len;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reads0 = src_reads;

        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len[LEN_W-1:0];
        cmd_incr  = incr;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);

        cyc = 1; acc = 0; stalls = 0; data_beat = 0; err_stage = 0; stall_left = stall_n;
        data_pend = 1'b0; prev_wait = 1'b0; finished = 1'b0;
        prev_addr = 32'h0; prev_trans = T_IDLE;
        while (!finished && cyc < 3000) begin
            trans = HTRANS;
            if (cyc == reset_at) begin
                HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; cmd_valid = 1'b0;
                @(posedge HCLK);
                @(negedge HCLK);
                check_eq("rst_htrans", 32'(HTRANS), 32'(T_IDLE));
                check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
                check_eq("rst_haddr", HADDR, 32'h0);
                check_eq("rst_beats_ok", 32'(beats_ok), 32'd0);
                HRESET = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    check_eq("rst_no_done", 32'(done), 32'd0);
                    @(negedge HCLK);
                end
                finished = 1'b1;
            end else if (done) begin
                cmd_valid = 1'b0;
                HREADY = 1'b1; HRESP = 1'b0;
                exp_cyc = (len == 0) ? 1 : (has_err ? err_beat + 3 + stalls : len + 2 + stalls);
                check_eq("done_cycle", 32'(cyc), 32'(exp_cyc));
                check_eq("err", 32'(err), 32'(has_err));
                check_eq("beats_ok", 32'(beats_ok), 32'(exp_ok));
                check_eq("addr_phases", 32'(acc), 32'(exp_acc));
                check_eq("src_reads", 32'(src_reads - reads0), 32'(exp_acc));
                check_eq("done_htrans", 32'(HTRANS), 32'(T_IDLE));
                check_eq("done_cmd_ready", 32'(cmd_ready), 32'd1);
                @(negedge HCLK);
                check_eq("done_pulse", 32'(done), 32'd0);
                finished = 1'b1;
            end else begin
                check_eq("busy_cmd_ready", 32'(cmd_ready), 32'd0);
                if (prev_wait && err_stage != 1) begin
                    check_eq("hold_haddr", HADDR, prev_addr);
                    check_eq("hold_htrans", 32'(trans), 32'(prev_trans));
                end
                if (err_stage == 1) begin
                    check_eq("err_idle", 32'(trans), 32'(T_IDLE));
                    rdy = 1'b1; rsp = 1'b1; err_stage = 2;
                end else if (data_pend && data_beat == err_beat && err_stage == 0) begin
                    rdy = 1'b0; rsp = 1'b1; err_stage = 1;
                end else if (data_pend && data_beat == stall_beat && stall_left > 0) begin
                    rdy = 1'b0; rsp = 1'b0; stall_left--;
                end else begin
                    rdy = ($urandom_range(0, 99) < ready_pct);
                    rsp = (!rdy && !data_pend) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                HREADY = rdy;
                HRESP  = rsp;
                if (!rdy) stalls++;
                if (data_pend) check_eq("hwdata", HWDATA, mem[data_beat[7:0]]);
                check_eq("hwrite", 32'(HWRITE), 32'(trans != T_IDLE));
                if (trans != T_IDLE) begin
                    check_eq("hsize", 32'(HSIZE), 32'd2);
                    check_eq("hburst", 32'(HBURST), incr ? 32'd1 : 32'd0);
                    if (rdy) begin
                        if (acc < len) begin
                            check_eq("haddr", HADDR, exp_addr[acc]);
                            check_eq("htrans", 32'(trans), 32'(exp_trans[acc]));
                        end else begin
                            check_eq("extra_addr_phase", 32'(acc), 32'(len - 1));
                        end
                        acc++;
                    end
                end
                prev_wait  = (trans != T_IDLE) && !rdy;
                prev_addr  = HADDR;
                prev_trans = trans;
                if (rdy) begin
                    data_pend = (trans != T_IDLE);
                    data_beat = acc - 1;
                end
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_addr  = $urandom;
                cmd_len   = LEN_W'($urandom);
                cmd_incr  = 1'($urandom_range(0, 1));
                cyc++;
                @(negedge HCLK);
            end
        end
        if (!finished) check_eq("timeout", 32'(cyc), 32'd0);
        cmd_valid = 1'b0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        @(negedge HCLK);
    endtask

    initial begin
        logic [31:0] r_addr;
        int r_len, r_eb;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        check_eq("reset_htrans", 32'(HTRANS), 32'(T_IDLE));
        check_eq("reset_haddr", HADDR, 32'h0);
        check_eq("reset_hwrite", 32'(HWRITE), 32'd0);
        check_eq("reset_hburst", 32'(HBURST), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        check_eq("reset_beats_ok", 32'(beats_ok), 32'd0);
        check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("reset_src_addr", 32'(src_addr), 32'd0);
        check_eq("reset_src_rd_en", 32'(src_rd_en), 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);

        run_cmd(32'h0000_0100, 1, 1'b0, 100, -1, 0, -1, -1);
        run_cmd(32'h0000_0200, 4, 1'b1, 100, -1, 0, -1, -1);
        run_cmd(32'h0000_0000, 3, 1'b1, 100, 0, 2, -1, -1);
        run_cmd(32'h0000_03F8, 4, 1'b1, 100, -1, 0, -1, -1);
        run_cmd(32'h0000_0600, 4, 1'b1, 100, -1, 0, 1, -1);
        run_cmd(32'h0000_0040, 0, 1'b1, 100, -1, 0, -1, -1);
        run_cmd(32'h0000_0500, 4, 1'b1, 100, -1, 0, -1, 3);
        run_cmd(32'h0000_0703, 3, 1'b0, 100, -1, 0, -1, -1);

        for (int t = 0; t < 40; t++) begin
            r_addr = $urandom & 32'h000F_FFFF;
            if ($urandom_range(0, 1) == 1) r_addr[9:4] = 6'h3F;
            r_len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            r_eb  = ($urandom_range(0, 3) == 0 && r_len > 0) ? int'($urandom_range(0, r_len - 1)) : -1;
            run_cmd(r_addr, r_len, 1'($urandom_range(0, 1)), int'($urandom_range(50, 100)),
                    -1, 0, r_eb, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
